// File: rtl/visualizer_pkg.sv
// Shared types and defaults for the bar visualizer (loader and VGA controller).
// No logic of its own; no latency or flow control.
package visualizer_pkg;

    localparam int VIS_NUM_BARS = 20;
    localparam int VIS_HEIGHT_W = 6;
    localparam int VIS_ADDR_W   = 6;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        PEND
    } state_t;

    // A single bar still needs a one-bit index.
    function automatic int idx_width(input int num_bars);
        return (num_bars > 1) ? $clog2(num_bars) : 1;
    endfunction

endpackage

// File: rtl/bar_peak_update.sv
// Next display height for one bar: direct copy, or peak-hold with saturating decay.
// Purely combinational, zero latency.
// No flow control; evaluated every cycle, used only on commit.
module bar_peak_update
    import visualizer_pkg::*;
#(
    parameter int HEIGHT_W   = VIS_HEIGHT_W,
    parameter int DECAY_STEP = 1
) (
    input  logic [HEIGHT_W-1:0] new_h,
    input  logic [HEIGHT_W-1:0] old_h,
    input  logic                peak_mode,
    output logic [HEIGHT_W-1:0] next_h
);

    always_comb begin
        next_h = new_h;
        if (peak_mode && (new_h < old_h)) begin
            next_h = (int'(old_h) > DECAY_STEP) ? HEIGHT_W'(int'(old_h) - DECAY_STEP) : '0;
        end
    end

endmodule

// File: rtl/bar_height_loader.sv
// Fetches NUM_BARS heights from bar RAM into a shadow buffer, commits on frame_sync.
// Fetch takes NUM_BARS+RAM_LATENCY cycles; commit lands the cycle after the frame_sync.
// No backpressure: RAM is read open-loop; one load per high level of start.
module bar_height_loader
    import visualizer_pkg::*;
#(
    parameter int NUM_BARS    = VIS_NUM_BARS,
    parameter int HEIGHT_W    = VIS_HEIGHT_W,
    parameter int ADDR_W      = VIS_ADDR_W,
    parameter int BASE_ADDR   = 0,
    parameter int RAM_LATENCY = 2,
    parameter int DECAY_STEP  = 1
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         frame_sync,
    input  logic                         peak_mode,
    output logic [ADDR_W-1:0]            ram_rdaddress,
    input  logic [HEIGHT_W-1:0]          ram_q,
    output logic [NUM_BARS*HEIGHT_W-1:0] heights,
    output logic                         busy,
    output logic                         done
);

    localparam int              IDX_W    = idx_width(NUM_BARS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BARS - 1);

    if (NUM_BARS < 1 || NUM_BARS > 64) begin : g_bad_num_bars
        $error("bar_height_loader: NUM_BARS must be 1..64");
    end
    if (RAM_LATENCY < 1 || RAM_LATENCY > 4) begin : g_bad_latency
        $error("bar_height_loader: RAM_LATENCY must be 1..4");
    end
    if (BASE_ADDR + NUM_BARS > 2**ADDR_W) begin : g_bad_range
        $error("bar_height_loader: bar window exceeds RAM address space");
    end

    state_t                 state_q, state_d;
    logic                   armed_q, armed_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [RAM_LATENCY-1:0] vld_q, vld_d;
    logic [IDX_W-1:0]       tag_q     [RAM_LATENCY];
    logic [IDX_W-1:0]       tag_d     [RAM_LATENCY];
    logic [HEIGHT_W-1:0]    shadow_q  [NUM_BARS];
    logic [HEIGHT_W-1:0]    shadow_d  [NUM_BARS];
    logic [HEIGHT_W-1:0]    heights_q [NUM_BARS];
    logic [HEIGHT_W-1:0]    heights_d [NUM_BARS];
    logic [HEIGHT_W-1:0]    peak_next [NUM_BARS];
    logic                   load_go, issue, commit;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Leaving DRAIN is decided on the shifted pipeline, so the last capture
    // and the move to PEND share a cycle; frame_sync in that cycle is ignored.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start && armed_q)   state_d = FETCH;
            FETCH:   if (idx_q == LAST_IDX)  state_d = DRAIN;
            DRAIN:   if (vld_d == '0)        state_d = PEND;
            PEND:    if (frame_sync)         state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_comb begin
        load_go = (state_q == IDLE) && start && armed_q;
        issue   = (state_q == FETCH);
        commit  = (state_q == PEND) && frame_sync && !reset;
        busy    = (state_q != IDLE);
        done    = commit;
    end

    always_comb begin
        armed_d = !start || (armed_q && !load_go);

        idx_d = idx_q;
        if (load_go) begin
            idx_d = '0;
        end else if (issue && (idx_q != LAST_IDX)) begin
            idx_d = idx_q + 1'b1;
        end

        addr_d = addr_q;
        if (load_go || issue) begin
            addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_d);
        end

        vld_d[0] = issue;
        tag_d[0] = idx_q;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end

        shadow_d = shadow_q;
        if (vld_q[RAM_LATENCY-1]) begin
            shadow_d[tag_q[RAM_LATENCY-1]] = ram_q;
        end

        heights_d = heights_q;
        if (commit) begin
            heights_d = peak_next;
        end
    end

    for (genvar g = 0; g < NUM_BARS; g++) begin : g_bar
        bar_peak_update #(
            .HEIGHT_W   (HEIGHT_W),
            .DECAY_STEP (DECAY_STEP)
        ) u_peak (
            .new_h     (shadow_q[g]),
            .old_h     (heights_q[g]),
            .peak_mode (peak_mode),
            .next_h    (peak_next[g])
        );
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            armed_q   <= 1'b1;
            idx_q     <= '0;
            addr_q    <= '0;
            vld_q     <= '0;
            tag_q     <= '{default: '0};
            shadow_q  <= '{default: '0};
            heights_q <= '{default: '0};
        end else begin
            armed_q   <= armed_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            vld_q     <= vld_d;
            tag_q     <= tag_d;
            shadow_q  <= shadow_d;
            heights_q <= heights_d;
        end
    end

    assign ram_rdaddress = addr_q;

    always_comb begin
        heights = '0;
        for (int i = 0; i < NUM_BARS; i++) begin
            heights[i*HEIGHT_W +: HEIGHT_W] = heights_q[i];
        end
    end

endmodule

// File: tb/tb_bar_height_loader.sv
// Bench for bar_height_loader: default instance scored through a commit queue,
// second instance (8 bars, latency 4, base 40) for address order and capture alignment.
module tb_bar_height_loader;

    localparam int N1 = 20;
    localparam int L1 = 2;
    localparam int N2 = 8;
    localparam int L2 = 4;
    localparam int B2 = 40;
    localparam int HW = 6;
    localparam int AW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, start, frame_sync, peak_mode;
    logic [AW-1:0]     addr1;
    logic [HW-1:0]     q1;
    logic [N1*HW-1:0]  heights1;
    logic              busy1, done1;

    logic              start2, fs2, peak2;
    logic [AW-1:0]     addr2;
    logic [HW-1:0]     q2;
    logic [N2*HW-1:0]  heights2;
    logic              busy2, done2;

    bar_height_loader dut (
        .CLOCK_50      (clk),
        .reset         (reset),
        .start         (start),
        .frame_sync    (frame_sync),
        .peak_mode     (peak_mode),
        .ram_rdaddress (addr1),
        .ram_q         (q1),
        .heights       (heights1),
        .busy          (busy1),
        .done          (done1)
    );

    bar_height_loader #(
        .NUM_BARS    (N2),
        .RAM_LATENCY (L2),
        .BASE_ADDR   (B2)
    ) dut2 (
        .CLOCK_50      (clk),
        .reset         (reset),
        .start         (start2),
        .frame_sync    (fs2),
        .peak_mode     (peak2),
        .ram_rdaddress (addr2),
        .ram_q         (q2),
        .heights       (heights2),
        .busy          (busy2),
        .done          (done2)
    );

    // Bar RAM shared by both instances, each with its own read latency.
    logic [HW-1:0] mem [64];
    logic [HW-1:0] rd1 [L1];
    logic [HW-1:0] rd2 [L2];

    always @(posedge clk) begin
        rd1[0] <= mem[addr1];
        for (int i = 1; i < L1; i++) rd1[i] <= rd1[i-1];
    end
    always @(posedge clk) begin
        rd2[0] <= mem[addr2];
        for (int j = 1; j < L2; j++) rd2[j] <= rd2[j-1];
    end
    assign q1 = rd1[L1-1];
    assign q2 = rd2[L2-1];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int               exp_h [N1];
    logic [N1*HW-1:0] sb_q [$];
    logic             chk_next = 1'b0;
    int               done_cnt = 0;

    task automatic commit_model(input logic mode);
        logic [N1*HW-1:0] v;
        int nw, od;
        v = '0;
        for (int i = 0; i < N1; i++) begin
            nw = int'(mem[i]);
            od = exp_h[i];
            if (!mode || nw >= od) exp_h[i] = nw;
            else                   exp_h[i] = (od > 1) ? od - 1 : 0;
            v[i*HW +: HW] = HW'(exp_h[i]);
        end
        sb_q.push_back(v);
    endtask

    always @(negedge clk) begin
        #2;
        if (chk_next) begin
            chk("sb_nonempty", 128'(sb_q.size() != 0), 128'(1));
            if (sb_q.size() != 0) chk("heights", 128'(heights1), 128'(sb_q.pop_front()));
        end
        chk_next = done1;
        if (done1) done_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_fs(input logic expect_done);
        frame_sync = 1'b1;
        #1;
        chk("done_on_fs", 128'(done1), 128'(expect_done));
        if (expect_done) commit_model(peak_mode);
        @(negedge clk);
        frame_sync = 1'b0;
    endtask

    task automatic do_load(input logic mode);
        start = 1'b1;
        cyc(1);
        chk("busy_load", 128'(busy1), 128'(1));
        cyc(30);
        start     = 1'b0;
        peak_mode = mode;
        pulse_fs(1'b1);
        cyc(1);
        chk("busy_idle", 128'(busy1), 128'(0));
    endtask

    initial begin
        logic             all_busy;
        int               d0;
        logic [N2*HW-1:0] e2;

        reset = 1'b1; start = 1'b0; frame_sync = 1'b0; peak_mode = 1'b0;
        start2 = 1'b0; fs2 = 1'b0; peak2 = 1'b0;
        for (int k = 0; k < 64; k++) mem[k] = HW'(k + 1);
        for (int i = 0; i < N1; i++) exp_h[i] = 0;
        cyc(3);
        chk("rst_busy", 128'(busy1), 128'(0));
        chk("rst_done", 128'(done1), 128'(0));
        chk("rst_heights", 128'(heights1), 128'(0));
        chk("rst_addr", 128'(addr1), 128'(0));
        chk("rst_busy2", 128'(busy2), 128'(0));
        reset = 1'b0;
        cyc(1);

        // Basic load, frame_sync 40 cycles after start.
        start = 1'b1;
        all_busy = 1'b1;
        for (int c = 0; c < 39; c++) begin
            cyc(1);
            if (!busy1) all_busy = 1'b0;
        end
        chk("busy_whole_load", 128'(all_busy), 128'(1));
        cyc(1);
        pulse_fs(1'b1);
        start = 1'b0;
        cyc(2);

        // start held for ~200 cycles with three frame_syncs: one load only.
        for (int k = 0; k < 64; k++) mem[k] = HW'(63 - k);
        d0 = done_cnt;
        start = 1'b1;
        cyc(40);  pulse_fs(1'b1);
        cyc(59);  pulse_fs(1'b0);
        cyc(59);  pulse_fs(1'b0);
        cyc(40);
        chk("one_done_held", 128'(done_cnt - d0), 128'(1));
        start = 1'b0;
        cyc(2);
        for (int k = 0; k < 64; k++) mem[k] = HW'((k * 3) & 63);
        d0 = done_cnt;
        do_load(1'b0);
        chk("second_load", 128'(done_cnt - d0), 128'(1));

        // Reset in the middle of FETCH with start left high.
        for (int k = 0; k < 64; k++) mem[k] = HW'(k ^ 21);
        start = 1'b1;
        cyc(5);
        reset = 1'b1;
        cyc(1);
        chk("midrst_busy", 128'(busy1), 128'(0));
        chk("midrst_heights", 128'(heights1), 128'(0));
        chk("midrst_addr", 128'(addr1), 128'(0));
        for (int i = 0; i < N1; i++) exp_h[i] = 0;
        reset = 1'b0;
        cyc(1);
        chk("restart_after_rst", 128'(busy1), 128'(1));
        cyc(30);
        start = 1'b0;
        pulse_fs(1'b1);
        cyc(2);

        // Peak-hold sequence.
        for (int k = 0; k < 64; k++) mem[k] = HW'(10);
        do_load(1'b0);
        for (int k = 0; k < 64; k++) mem[k] = HW'(4);
        do_load(1'b1);
        chk("peak_decay1", 128'(heights1[HW-1:0]), 128'(9));
        do_load(1'b1);
        chk("peak_decay2", 128'(heights1[HW-1:0]), 128'(8));
        for (int k = 0; k < 64; k++) mem[k] = (k < 10) ? HW'(12) : HW'(0);
        do_load(1'b1);
        chk("peak_rise", 128'(heights1[HW-1:0]), 128'(12));
        for (int k = 0; k < 64; k++) mem[k] = HW'(0);
        do_load(1'b0);
        do_load(1'b1);
        chk("peak_floor", 128'(heights1[HW-1:0]), 128'(0));
        peak_mode = 1'b0;

        // frame_sync during FETCH and on the last DRAIN cycle is ignored.
        for (int k = 0; k < 64; k++) mem[k] = HW'(k + 7);
        start = 1'b1;
        cyc(5);   pulse_fs(1'b0);
        cyc(16);  pulse_fs(1'b0);
        cyc(6);
        chk("busy_pend", 128'(busy1), 128'(1));
        cyc(1);
        start = 1'b0;
        pulse_fs(1'b1);
        cyc(2);

        // Second instance: address order, DRAIN length, capture alignment.
        for (int i = 0; i < N2; i++) mem[B2 + i] = HW'(i * 7 + 5);
        e2 = '0;
        for (int i = 0; i < N2; i++) e2[i*HW +: HW] = HW'(i * 7 + 5);
        start2 = 1'b1;
        for (int k = 0; k < N2; k++) begin
            cyc(1);
            chk("addr2_seq", 128'(addr2), 128'(B2 + k));
        end
        cyc(4);
        chk("addr2_hold", 128'(addr2), 128'(B2 + N2 - 1));
        fs2 = 1'b1;
        #1;
        chk("done2_drain_end", 128'(done2), 128'(0));
        cyc(1);
        fs2 = 1'b0;
        cyc(1);
        fs2 = 1'b1;
        #1;
        chk("done2_commit", 128'(done2), 128'(1));
        cyc(1);
        fs2 = 1'b0;
        start2 = 1'b0;
        #1;
        chk("heights2", 128'(heights2), 128'(e2));
        chk("busy2_idle", 128'(busy2), 128'(0));

        cyc(3);
        chk("sb_drained", 128'(sb_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bar_height_loader.md
Name: bar_height_loader

Overview:
Parametrised successor to the fixed 20-bar height fetch that feeds the VGA controller. It reads NUM_BARS bar heights from the Nios-written bar RAM, using a configurable RAM read latency, into a shadow buffer. It then commits the shadow buffer to the display registers on a frame boundary, so the VGA controller never sees a half-updated set. An optional peak-hold mode keeps the larger of the new and old heights and decays old peaks by a fixed step per commit.

Parameters:
NUM_BARS, 20, number of bars fetched and output (1..64)
HEIGHT_W, 6, bits per bar height
ADDR_W, 6, bar RAM address width
BASE_ADDR, 0, RAM address of bar 0; elaboration error if BASE_ADDR+NUM_BARS > 2**ADDR_W
RAM_LATENCY, 2, cycles from ram_rdaddress driven to matching ram_q valid (1..4)
DECAY_STEP, 1, amount subtracted from a held peak per commit in peak mode

Ports:
CLOCK_50  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  level request from Nios (data_back); one load per high level
frame_sync  in  1  one-cycle pulse at start of vertical blanking
peak_mode  in  1  0 = direct update, 1 = peak-hold with decay; sampled at commit
ram_rdaddress  out  ADDR_W  bar RAM read address
ram_q  in  HEIGHT_W  bar RAM read data
heights  out  NUM_BARS*HEIGHT_W  display heights; bar i at [i*HEIGHT_W +: HEIGHT_W]
busy  out  1  high from load start until commit (control_bit equivalent)
done  out  1  one-cycle pulse on the commit cycle

Behaviour:
- Reset (synchronous, highest priority, valid in any state): state=IDLE; armed=1; ram_rdaddress=0; busy=0; done=0; heights and shadow all 0; capture pipeline cleared. Any in-flight load is abandoned.
- armed: cleared when a load starts; set again in any cycle where start=0.
- IDLE: if start=1 and armed=1, go to FETCH next cycle, set busy=1 and clear the issue index. If start is held high through reset, exactly one load follows.
- FETCH: issue one address per cycle, ram_rdaddress = BASE_ADDR + idx for idx = 0..NUM_BARS-1. A valid/index tag enters a RAM_LATENCY-deep shift register. When the tag emerges, shadow[tag] <= ram_q. After the last issue, go to DRAIN.
- DRAIN: wait until the pipeline is empty (last capture written), then go to PEND. Total fetch time is NUM_BARS+RAM_LATENCY cycles from entering FETCH.
- PEND: on the first frame_sync seen while in PEND, commit, pulse done for 1 cycle, set busy=0 and return to IDLE in the same cycle. A frame_sync in the cycle that enters PEND is not used; the next one is. frame_sync during FETCH or DRAIN is ignored.
- Commit, peak_mode=0: heights[i] <= shadow[i] for all i.
- Commit, peak_mode=1: heights[i] <= shadow[i] if shadow[i] >= heights[i], otherwise heights[i] - DECAY_STEP, saturating at 0. All compares are unsigned HEIGHT_W-bit.
- heights changes only on a commit cycle or at reset.
- start going low mid-load does not abort the load; it only re-arms.
- ram_rdaddress holds its last value outside FETCH.

Decomposition:
- Package visualizer_pkg holds: the state enum (IDLE, FETCH, DRAIN, PEND); default constants for NUM_BARS, HEIGHT_W and ADDR_W shared with the VGA controller; a function that computes the index width as clog2(NUM_BARS).
- One sub-module, bar_peak_update: a combinational per-bar function of new, old, peak_mode and DECAY_STEP giving next, generated NUM_BARS times.

Test Plan:
- RAM preloaded with addr k -> k+1, defaults; raise start; pulse frame_sync 40 cycles later -> busy high for the whole load; done pulses on the frame_sync cycle; heights bar i = i+1 for i = 0..19.
- Hold start high for 200 cycles with 3 frame_syncs -> exactly one done; raise start again after it drops -> second load occurs.
- peak_mode=1, heights all 10, RAM all 4 -> after commit 9; second commit 8; with RAM 12 -> 12; height 0 with new 0 stays 0 (no underflow).
- RAM_LATENCY=4, NUM_BARS=8, BASE_ADDR=40 -> addresses 40..47 on consecutive cycles; shadow captures aligned; DRAIN lasts until cycle 12 after FETCH entry.
- Assert reset mid-FETCH -> next cycle busy=0, heights=0, state IDLE; with start still high a fresh load starts after reset deasserts.
- frame_sync pulses during FETCH and on the PEND entry cycle -> ignored; commit happens on the following frame_sync only.
